// File: rtl/ex_stage_if.sv
// Decode-to-execute handshake bundle.
// The decode stage drives an operation; ex_stage answers with id_ready.
interface ex_stage_if;
  logic        id_valid;
  logic        id_ready;
  logic [7:0]  alu_op;
  logic [2:0]  alu_sel;
  logic [31:0] src_data1;
  logic [31:0] src_data2;
  logic [4:0]  wr_addr;
  logic        wr_en;

  modport master (
    output id_valid, alu_op, alu_sel,
    output src_data1, src_data2,
    output wr_addr, wr_en,
    input  id_ready
  );

  modport slave (
    input  id_valid, alu_op, alu_sel,
    input  src_data1, src_data2,
    input  wr_addr, wr_en,
    output id_ready
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: logic/shift/move ops with one-cycle result,
// HI/LO registers and a 32-cycle shift-add multiplier.
module ex_stage (
  input  logic        clk,
  input  logic        reset_n,
  ex_stage_if.slave   id,
  output logic        ex_valid,
  output logic        ex_wr_en,
  output logic [4:0]  ex_wr_addr,
  output logic [31:0] ex_wr_data,
  output logic        ex_rewrite_en,
  output logic [4:0]  ex_rewrite_addr,
  output logic [31:0] ex_rewrite_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [7:0] OP_AND   = 8'h24;
  localparam logic [7:0] OP_OR    = 8'h25;
  localparam logic [7:0] OP_XOR   = 8'h26;
  localparam logic [7:0] OP_NOR   = 8'h27;
  localparam logic [7:0] OP_SLL   = 8'h7C;
  localparam logic [7:0] OP_SRL   = 8'h02;
  localparam logic [7:0] OP_SRA   = 8'h03;
  localparam logic [7:0] OP_MOVZ  = 8'h0A;
  localparam logic [7:0] OP_MOVN  = 8'h0B;
  localparam logic [7:0] OP_MFHI  = 8'h10;
  localparam logic [7:0] OP_MTHI  = 8'h11;
  localparam logic [7:0] OP_MFLO  = 8'h12;
  localparam logic [7:0] OP_MTLO  = 8'h13;
  localparam logic [7:0] OP_MULT  = 8'h18;
  localparam logic [7:0] OP_MULTU = 8'h19;

  typedef enum logic [1:0] {
    IDLE,
    MUL_BUSY,
    MUL_DONE
  } state_t;

  state_t state, state_nx;

  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [63:0] mcand;
  logic [31:0] mplr;
  logic        neg;

  logic        accept;
  logic        sel_log, sel_sh, sel_mov, sel_mul;
  logic [31:0] a, b;
  logic [4:0]  sh;
  logic [31:0] res;
  logic        known, cond;
  logic        is_mul, mul_sgn;
  logic        mth, mtl;
  logic        wen;
  logic [31:0] mag1, mag2;

  assign id.id_ready = (state == IDLE);
  assign accept      = id.id_valid && id.id_ready;

  assign a  = id.src_data1;
  assign b  = id.src_data2;
  assign sh = id.src_data1[4:0];

  assign sel_log = (id.alu_sel == 3'b001);
  assign sel_sh  = (id.alu_sel == 3'b010);
  assign sel_mov = (id.alu_sel == 3'b011);
  assign sel_mul = (id.alu_sel == 3'b100);

  always_comb begin
    res     = '0;
    known   = 1'b0;
    cond    = 1'b1;
    is_mul  = 1'b0;
    mul_sgn = 1'b0;
    mth     = 1'b0;
    mtl     = 1'b0;
    unique case (1'b1)
      sel_log: begin
        known = 1'b1;
        case (id.alu_op)
          OP_AND:  res = a & b;
          OP_OR:   res = a | b;
          OP_XOR:  res = a ^ b;
          OP_NOR:  res = ~(a | b);
          default: known = 1'b0;
        endcase
      end
      sel_sh: begin
        known = 1'b1;
        case (id.alu_op)
          OP_SLL:  res = b << sh;
          OP_SRL:  res = b >> sh;
          OP_SRA:  res = $unsigned($signed(b) >>> sh);
          default: known = 1'b0;
        endcase
      end
      sel_mov: begin
        case (id.alu_op)
          OP_MOVZ: begin
            res   = a;
            known = 1'b1;
            cond  = (b == '0);
          end
          OP_MOVN: begin
            res   = a;
            known = 1'b1;
            cond  = (b != '0);
          end
          OP_MFHI: begin
            res   = hi;
            known = 1'b1;
          end
          OP_MFLO: begin
            res   = lo;
            known = 1'b1;
          end
          OP_MTHI: mth = 1'b1;
          OP_MTLO: mtl = 1'b1;
          default: ;
        endcase
      end
      sel_mul: begin
        is_mul  = (id.alu_op == OP_MULT) ||
                  (id.alu_op == OP_MULTU);
        mul_sgn = (id.alu_op == OP_MULT);
      end
      default: ;
    endcase
  end

  assign wen = known && cond && id.wr_en &&
               (id.wr_addr != 5'd0);

  // Signed multiply runs on magnitudes; -0x80000000 wraps to 2^31.
  assign mag1 = (mul_sgn && a[31]) ? (~a + 32'd1) : a;
  assign mag2 = (mul_sgn && b[31]) ? (~b + 32'd1) : b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (accept && is_mul) state_nx = MUL_BUSY;
      MUL_BUSY: if (cnt == 5'd31)     state_nx = MUL_DONE;
      MUL_DONE: state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
      neg   <= 1'b0;
    end else if (accept && is_mul) begin
      cnt   <= '0;
      acc   <= '0;
      mcand <= {32'd0, mag1};
      mplr  <= mag2;
      neg   <= mul_sgn && (a[31] ^ b[31]);
    end else if (state == MUL_BUSY) begin
      if (mplr[0]) acc <= acc + mcand;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      cnt   <= cnt + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi <= '0;
      lo <= '0;
    end else if (state == MUL_DONE) begin
      {hi, lo} <= neg ? (~acc + 64'd1) : acc;
    end else if (accept) begin
      if (mth) hi <= a;
      if (mtl) lo <= a;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid   <= 1'b0;
      ex_wr_en   <= 1'b0;
      ex_wr_addr <= '0;
      ex_wr_data <= '0;
    end else if (accept && !is_mul) begin
      ex_valid   <= 1'b1;
      ex_wr_en   <= wen;
      ex_wr_addr <= id.wr_addr;
      ex_wr_data <= res;
    end else begin
      ex_valid   <= 1'b0;
      ex_wr_en   <= 1'b0;
      ex_wr_addr <= '0;
      ex_wr_data <= '0;
    end
  end

  assign ex_rewrite_en   = ex_wr_en;
  assign ex_rewrite_addr = ex_wr_addr;
  assign ex_rewrite_data = ex_wr_data;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: vector table, hand sequences
// and a randomized stream against a behavioural model.
module tb_ex_stage;

  localparam logic [7:0] AND_  = 8'h24;
  localparam logic [7:0] OR_   = 8'h25;
  localparam logic [7:0] XOR_  = 8'h26;
  localparam logic [7:0] NOR_  = 8'h27;
  localparam logic [7:0] SLL_  = 8'h7C;
  localparam logic [7:0] SRL_  = 8'h02;
  localparam logic [7:0] SRA_  = 8'h03;
  localparam logic [7:0] MOVZ_ = 8'h0A;
  localparam logic [7:0] MOVN_ = 8'h0B;
  localparam logic [7:0] MFHI_ = 8'h10;
  localparam logic [7:0] MTHI_ = 8'h11;
  localparam logic [7:0] MFLO_ = 8'h12;
  localparam logic [7:0] MTLO_ = 8'h13;
  localparam logic [7:0] MULT_ = 8'h18;
  localparam logic [7:0] MULTU_ = 8'h19;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  ex_stage_if bus ();

  logic        ex_valid, ex_wr_en, ex_rewrite_en;
  logic [4:0]  ex_wr_addr, ex_rewrite_addr;
  logic [31:0] ex_wr_data, ex_rewrite_data;
  logic [31:0] hi, lo;

  ex_stage dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .id              (bus.slave),
    .ex_valid        (ex_valid),
    .ex_wr_en        (ex_wr_en),
    .ex_wr_addr      (ex_wr_addr),
    .ex_wr_data      (ex_wr_data),
    .ex_rewrite_en   (ex_rewrite_en),
    .ex_rewrite_addr (ex_rewrite_addr),
    .ex_rewrite_data (ex_rewrite_data),
    .hi              (hi),
    .lo              (lo)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] sel,
                       input logic [7:0] op,
                       input logic [31:0] s1, s2,
                       input logic [4:0] ad,
                       input logic w);
    bus.id_valid  = 1'b1;
    bus.alu_sel   = sel;
    bus.alu_op    = op;
    bus.src_data1 = s1;
    bus.src_data2 = s2;
    bus.wr_addr   = ad;
    bus.wr_en     = w;
  endtask

  // Checks the write port and its forwarding copy together.
  task automatic chk_wr(input string nm,
                        input logic en,
                        input logic [4:0] ad,
                        input logic [31:0] d,
                        input logic ck_ad,
                        input logic ck_d);
    chk({nm, ".valid"}, 64'(ex_valid), 64'd1);
    chk({nm, ".en"}, {ex_wr_en, ex_rewrite_en}, {en, en});
    if (ck_ad)
      chk({nm, ".addr"}, {ex_wr_addr, ex_rewrite_addr}, {ad, ad});
    if (ck_d)
      chk({nm, ".data"}, {ex_wr_data, ex_rewrite_data}, {d, d});
  endtask

  task automatic chk_idle(input string nm);
    chk(nm, {ex_valid, ex_wr_en, ex_rewrite_en, ex_wr_addr,
             ex_wr_data, ex_rewrite_data},
        '0);
  endtask

  // Behavioural model of a single-cycle operation.
  function automatic void ref_op(input logic [2:0] sel,
                                 input logic [7:0] op,
                                 input logic [31:0] s1, s2,
                                 input logic [4:0] ad,
                                 input logic w,
                                 output logic en,
                                 output logic [31:0] d,
                                 output logic set_hi,
                                 output logic set_lo);
    int unsigned sh = s1[4:0];
    longint den = longint'(1) << sh;
    longint x;
    longint q;
    logic writes = 1'b0;
    d = '0;
    set_hi = 1'b0;
    set_lo = 1'b0;
    if (sel == 3'd1) begin
      writes = 1'b1;
      case (op)
        AND_: d = s1 & s2;
        OR_:  d = s1 | s2;
        XOR_: d = s1 ^ s2;
        NOR_: d = ~(s1 | s2);
        default: writes = 1'b0;
      endcase
    end else if (sel == 3'd2) begin
      writes = 1'b1;
      x = longint'(s2);
      case (op)
        SLL_: begin q = x * den; d = q[31:0]; end
        SRL_: begin q = x / den; d = q[31:0]; end
        SRA_: begin
          x = longint'($signed(s2));
          q = (x >= 0) ? x / den : -((-x + den - 1) / den);
          d = q[31:0];
        end
        default: writes = 1'b0;
      endcase
    end else if (sel == 3'd3) begin
      case (op)
        MOVZ_: begin d = s1; writes = (s2 == 0); end
        MOVN_: begin d = s1; writes = (s2 != 0); end
        MFHI_: begin d = hi_m; writes = 1'b1; end
        MFLO_: begin d = lo_m; writes = 1'b1; end
        MTHI_: set_hi = 1'b1;
        MTLO_: set_lo = 1'b1;
        default: ;
      endcase
    end
    en = writes && w && (ad != 0);
  endfunction

  task automatic run_mul(input string nm,
                         input logic sgn,
                         input logic [31:0] x, y);
    logic [63:0] p;
    int bad = 0;
    if (sgn) p = 64'(longint'($signed(x)) * longint'($signed(y)));
    else     p = {32'd0, x} * {32'd0, y};
    drive(3'd4, sgn ? MULT_ : MULTU_, x, y, 5'd9, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      if (bus.id_ready !== 1'b0 || ex_valid !== 1'b0 ||
          ex_wr_en !== 1'b0 || hi !== hi_m || lo !== lo_m)
        bad++;
      drive(3'($urandom_range(0, 4)), 8'($urandom),
            $urandom, $urandom, 5'($urandom), 1'b1);
      @(negedge clk);
    end
    bus.id_valid = 1'b0;
    chk({nm, ".busy"}, 64'(bad), 64'd0);
    @(negedge clk);
    chk({nm, ".ready"}, 64'(bus.id_ready), 64'd1);
    chk({nm, ".hilo"}, {hi, lo}, p);
    hi_m = p[63:32];
    lo_m = p[31:0];
  endtask

  typedef struct {
    logic [2:0]  sel;
    logic [7:0]  op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [4:0]  ad;
    logic        w;
    logic        en;
    logic [31:0] d;
    logic        ck_d;
  } vec_t;

  vec_t tbl[16];

  logic [7:0] ops_log[4] = '{AND_, OR_, XOR_, NOR_};
  logic [7:0] ops_sh[3]  = '{SLL_, SRL_, SRA_};
  logic [7:0] ops_mv[6]  = '{MOVZ_, MOVN_, MFHI_, MTHI_,
                             MFLO_, MTLO_};

  initial begin
    logic        e_en, s_hi, s_lo, v;
    logic [31:0] e_d, r1, r2;
    logic [2:0]  sel;
    logic [7:0]  op;
    logic [4:0]  ad;
    logic        w;

    tbl[0]  = '{3'd1, OR_,  32'h0000FF00, 32'h00F0F0F0, 5'd5, 1,
                1, 32'h00F0FFF0, 1};
    tbl[1]  = '{3'd2, SRA_, 32'd4, 32'h80000010, 5'd6, 1,
                1, 32'hF8000001, 1};
    tbl[2]  = '{3'd2, SLL_, 32'd0, 32'h12345678, 5'd7, 1,
                1, 32'h12345678, 1};
    tbl[3]  = '{3'd3, MOVZ_, 32'hAAAA0000, 32'd1, 5'd8, 1,
                0, 32'h0, 0};
    tbl[4]  = '{3'd3, MOVN_, 32'h11223344, 32'd1, 5'd7, 1,
                1, 32'h11223344, 1};
    tbl[5]  = '{3'd1, OR_,  32'h0000FF00, 32'h00F0F0F0, 5'd0, 1,
                0, 32'h0, 0};
    tbl[6]  = '{3'd1, AND_, 32'hF0F0F0F0, 32'hFF00FF00, 5'd1, 1,
                1, 32'hF000F000, 1};
    tbl[7]  = '{3'd1, XOR_, 32'hFFFF0000, 32'h0F0F0F0F, 5'd2, 1,
                1, 32'hF0F00F0F, 1};
    tbl[8]  = '{3'd1, NOR_, 32'h0F0F0000, 32'h000000F0, 5'd3, 1,
                1, 32'hF0F0FF0F, 1};
    tbl[9]  = '{3'd2, SRL_, 32'd8, 32'h80000000, 5'd4, 1,
                1, 32'h00800000, 1};
    tbl[10] = '{3'd2, SRA_, 32'd31, 32'h80000000, 5'd10, 1,
                1, 32'hFFFFFFFF, 1};
    tbl[11] = '{3'd2, SLL_, 32'd31, 32'h00000001, 5'd11, 1,
                1, 32'h80000000, 1};
    tbl[12] = '{3'd3, MOVZ_, 32'hCAFEF00D, 32'd0, 5'd12, 1,
                1, 32'hCAFEF00D, 1};
    tbl[13] = '{3'd1, 8'h55, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 1,
                0, 32'h0, 1};
    tbl[14] = '{3'd0, OR_,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd14, 1,
                0, 32'h0, 1};
    tbl[15] = '{3'd1, AND_, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd15, 0,
                0, 32'h0, 0};

    reset_n = 1'b0;
    bus.id_valid = 1'b0;
    drive(3'd0, 8'h0, '0, '0, '0, 1'b0);
    bus.id_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("reset.out");
    chk("reset.hilo", {hi, lo}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset.ready", 64'(bus.id_ready), 64'd1);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].sel, tbl[i].op, tbl[i].s1, tbl[i].s2,
            tbl[i].ad, tbl[i].w);
      @(negedge clk);
      chk_wr($sformatf("vec%0d", i), tbl[i].en, tbl[i].ad,
             tbl[i].d, tbl[i].en, tbl[i].ck_d);
      bus.id_valid = 1'b0;
      @(negedge clk);
      chk_idle($sformatf("vec%0d.idle", i));
    end

    drive(3'd3, MTHI_, 32'hDEADBEEF, 32'd0, 5'd4, 1'b1);
    @(negedge clk);
    chk("mthi.en", 64'(ex_wr_en), 64'd0);
    drive(3'd3, MFHI_, 32'd0, 32'd0, 5'd3, 1'b1);
    @(negedge clk);
    chk_wr("mfhi", 1'b1, 5'd3, 32'hDEADBEEF, 1'b1, 1'b1);
    drive(3'd3, MTLO_, 32'h0BADF00D, 32'd0, 5'd4, 1'b1);
    @(negedge clk);
    drive(3'd3, MFLO_, 32'd0, 32'd0, 5'd21, 1'b1);
    @(negedge clk);
    chk_wr("mflo", 1'b1, 5'd21, 32'h0BADF00D, 1'b1, 1'b1);
    hi_m = 32'hDEADBEEF;
    lo_m = 32'h0BADF00D;

    run_mul("mult", 1'b1, 32'hFFFFFFFF, 32'h00000003);
    chk("mult.const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    drive(3'd3, MFHI_, 32'd0, 32'd0, 5'd3, 1'b1);
    @(negedge clk);
    chk_wr("mfhi.post", 1'b1, 5'd3, 32'hFFFFFFFF, 1'b1, 1'b1);
    bus.id_valid = 1'b0;
    @(negedge clk);
    run_mul("multu", 1'b0, 32'hFFFFFFFF, 32'h00000003);
    chk("multu.const", {hi, lo}, 64'h00000002_FFFFFFFD);
    run_mul("mult.min", 1'b1, 32'h80000000, 32'h80000000);
    chk("mult.min.c", {hi, lo}, 64'h40000000_00000000);
    run_mul("mult.minx1", 1'b1, 32'h80000000, 32'h00000001);
    chk("mult.minx1.c", {hi, lo}, 64'hFFFFFFFF_80000000);

    for (int it = 0; it < 400; it++) begin
      if (it % 50 == 25) begin
        run_mul($sformatf("rmul%0d", it), 1'($urandom),
                $urandom, $urandom);
        continue;
      end
      v = ($urandom_range(0, 3) != 0);
      sel = 3'($urandom_range(0, 7));
      r1 = $urandom;
      r2 = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      ad = 5'($urandom);
      w = ($urandom_range(0, 4) != 0);
      op = 8'($urandom);
      if ($urandom_range(0, 9) != 0) begin
        case (sel)
          3'd1: op = ops_log[$urandom_range(0, 3)];
          3'd2: op = ops_sh[$urandom_range(0, 2)];
          3'd3: op = ops_mv[$urandom_range(0, 5)];
          default: ;
        endcase
      end
      if (sel == 3'd4 && (op == MULT_ || op == MULTU_))
        op = 8'h55;
      drive(sel, op, r1, r2, ad, w);
      bus.id_valid = v;
      ref_op(sel, op, r1, r2, ad, w, e_en, e_d, s_hi, s_lo);
      @(negedge clk);
      if (v) begin
        chk_wr($sformatf("rnd%0d", it), e_en, ad, e_d,
               e_en, e_en);
        if (s_hi) hi_m = r1;
        if (s_lo) lo_m = r1;
      end else begin
        chk_idle($sformatf("rnd%0d.idle", it));
      end
      chk($sformatf("rnd%0d.hilo", it), {hi, lo}, {hi_m, lo_m});
    end

    drive(3'd4, MULT_, 32'd7, 32'd9, 5'd1, 1'b1);
    @(negedge clk);
    bus.id_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst.mid.hilo", {hi, lo}, 64'd0);
    chk_idle("rst.mid.out");
    @(negedge clk);
    reset_n = 1'b1;
    hi_m = '0;
    lo_m = '0;
    @(negedge clk);
    chk("rst.ready", 64'(bus.id_ready), 64'd1);
    repeat (40) @(negedge clk);
    chk("rst.abort", {hi, lo, 31'd0, bus.id_ready},
        {64'd0, 32'd1});
    run_mul("multu79", 1'b0, 32'd7, 32'd9);
    chk("multu79.c", {hi, lo}, 64'd63);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on its rising edge.
REQ-002 reset_n  in  1  asynchronous, active-low reset; clears all state immediately when low.
REQ-003 id_valid  in  1  decoded operation present this cycle.
REQ-004 id_ready  out  1  block can accept an operation this cycle.
REQ-005 alu_op  in  8  operation code: AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SLL 0x7C, SRL 0x02, SRA 0x03, MOVZ 0x0A, MOVN 0x0B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19.
REQ-006 alu_sel  in  3  operation class: 000 nop, 001 logic, 010 shift, 011 move, 100 multiply.
REQ-007 src_data1, src_data2  in  32 each  operands; shift amount = src_data1[4:0], shifted value = src_data2.
REQ-008 wr_addr  in  5  destination GPR; wr_en  in  1  destination write requested.
REQ-009 ex_valid  out  1  registered result slot holds an accepted operation.
REQ-010 ex_wr_en, ex_wr_addr, ex_wr_data  out  1/5/32  registered GPR write toward memory stage.
REQ-011 ex_rewrite_en, ex_rewrite_addr, ex_rewrite_data  out  1/5/32  forwarding copy to decode; equal to ex_wr_en/ex_wr_addr/ex_wr_data.
REQ-012 hi, lo  out  32 each  current HI/LO register contents.

Function
REQ-013 Accept = id_valid && id_ready at a rising edge; id_ready = 1 only in state IDLE.
REQ-014 States: IDLE, MUL_BUSY, MUL_DONE; IDLE->MUL_BUSY on accepted alu_sel=100; MUL_BUSY->MUL_DONE after 32 iterations; MUL_DONE->IDLE after one cycle.
REQ-015 Non-multiply accept: result registered at the accept edge; ex_valid=1 the following cycle; latency one cycle.
REQ-016 Cycle with no accept: ex_valid=0, ex_wr_en=0 next cycle; ex_wr_addr/ex_wr_data forced to 0.
REQ-017 Logic: AND/OR/XOR/NOR of src_data1, src_data2.
REQ-018 Shift: SLL logical left, SRL logical right, SRA arithmetic right of src_data2 by src_data1[4:0]; amount 0 returns src_data2 unchanged.
REQ-019 MOVZ: result src_data1, write only if src_data2==0. MOVN: write only if src_data2!=0. Condition evaluated here regardless of wr_en.
REQ-020 MFHI/MFLO: result = hi/lo value present at the accept edge.
REQ-021 MTHI/MTLO: hi/lo <= src_data1 at the accept edge; ex_wr_en=0.
REQ-022 ex_wr_en = accepted && wr_en && (wr_addr!=0) && (MOVZ/MOVN condition where applicable); writes to r0 always suppressed.
REQ-023 Unknown alu_op within a class, or alu_sel=000: ex_wr_data=0, ex_wr_en=0, ex_valid=1.
REQ-024 MULTU: unsigned 32x32->64 shift-add, one partial-product bit per MUL_BUSY cycle, 5-bit iteration counter 0..31.
REQ-025 MULT: multiply magnitudes; negate 64-bit product when operand signs differ; 0x80000000 operands handled correctly (two's complement magnitude 2^31).
REQ-026 In MUL_DONE: {hi,lo} <= product; multiply produces no GPR write; ex_valid=0 for all multiply cycles.
REQ-027 Multiply timing: accept at edge E0; hi/lo updated at edge E33; id_ready high again from edge E33; an MFHI presented then and accepted at E34 returns the new hi.
REQ-028 Operands latched at accept; input changes during MUL_BUSY are ignored.

Reset
REQ-029 reset_n low, at any time including mid-multiply: state IDLE, counter 0, hi=lo=0, product accumulator 0, ex_valid=0, ex_wr_en=0, ex_wr_addr=0, ex_wr_data=0, ex_rewrite_* = 0; id_ready=1 once reset_n is high.
REQ-030 Multiply in progress when reset asserts: aborted; no hi/lo update after release.

Verification
REQ-031 OR src1=0x0000FF00 src2=0x00F0F0F0 wr_addr=5 wr_en=1 -> next cycle ex_wr_en=1, addr 5, data 0x00F0FFF0, ex_rewrite_* identical.
REQ-032 SRA src1=4 src2=0x80000010 -> 0xF8000001; SLL by 0 of 0x12345678 -> 0x12345678.
REQ-033 MOVZ src2=1 wr_en=1 -> ex_wr_en=0; MOVN src2=1 -> ex_wr_en=1, data=src1; OR to r0 -> ex_wr_en=0.
REQ-034 MULT 0xFFFFFFFF x 0x00000003 -> id_ready low for edges E1..E32, then hi=0xFFFFFFFF, lo=0xFFFFFFFD at E33; MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFD.
REQ-035 MTHI 0xDEADBEEF followed next cycle by MFHI wr_addr=3 -> ex_wr_data=0xDEADBEEF.
REQ-036 reset_n low at iteration 10 of MULT 7x9 -> hi=lo=0 and IDLE; a new MULTU 7x9 afterwards -> lo=63, hi=0.
